// File: rtl/mem_resp_queue_if.sv
// Handshake and bus bundle for mem_resp_queue: EXE enqueue side, data-SRAM
// response side, flush, and the WB dequeue side.
interface mem_resp_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_gr_we;
  logic [4:0]  in_dest;
  logic [31:0] in_pc;
  logic        in_exc;
  logic        in_is_mem;
  logic [4:0]  in_load_op;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        flush;
  logic        data_ok;
  logic [31:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_gr_we;
  logic [4:0]  out_dest;
  logic [31:0] out_pc;
  logic        out_exc;
  logic [31:0] out_result;
  logic [4:0]  fwd_dest;

  modport slave (
    input  in_valid, in_gr_we, in_dest, in_pc, in_exc, in_is_mem, in_load_op,
           in_addr_lo, in_result, flush, data_ok, rdata, out_ready,
    output in_ready, out_valid, out_gr_we, out_dest, out_pc, out_exc,
           out_result, fwd_dest
  );

  modport master (
    output in_valid, in_gr_we, in_dest, in_pc, in_exc, in_is_mem, in_load_op,
           in_addr_lo, in_result, flush, data_ok, rdata, out_ready,
    input  in_ready, out_valid, out_gr_we, out_dest, out_pc, out_exc,
           out_result, fwd_dest
  );
endinterface

// File: rtl/mem_resp_queue.sv
// In-order memory-response queue between EXE and WB with flush-time response
// dropping. Define MEM_RESP_BYPASS_EN for a combinational data_ok-to-WB path.
module mem_resp_queue #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             resetn,
  mem_resp_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, drop_q, drop_d;

  logic          gr_we_q   [DEPTH];
  logic [4:0]    dest_q    [DEPTH];
  logic [31:0]   pc_q      [DEPTH];
  logic          exc_q     [DEPTH];
  logic          need_q    [DEPTH];
  logic          done_q    [DEPTH];
  logic [4:0]    load_op_q [DEPTH];
  logic [1:0]    addr_q    [DEPTH];
  logic [31:0]   data_q    [DEPTH];

  logic [CW-1:0] pend_s;
  logic          resp_found_s;
  logic [PW-1:0] resp_idx_s, scan_idx_s;
  logic          accept_resp_s, store_resp_s, head_cpl_s, out_valid_s;
  logic          in_ready_s, enq_s, deq_s;
  logic [31:0]   ext_s, result_s;
`ifdef MEM_RESP_BYPASS_EN
  logic          byp_hit_s;
`endif

  function automatic logic [31:0] extract_load(input logic [4:0] op,
                                               input logic [1:0] lo,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    if (op[1])      r = {{24{b[7]}}, b};
    else if (op[3]) r = {24'd0, b};
    else if (op[2]) r = {{16{h[15]}}, h};
    else if (op[4]) r = {16'd0, h};
    else            r = d;
    return r;
  endfunction

  // Find the oldest entry still waiting for data_ok and count all such entries
  always_comb begin
    pend_s       = {CW{1'b0}};
    resp_found_s = 1'b0;
    resp_idx_s   = head_q;
    scan_idx_s   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = head_q + PW'(i);
      if ((CW'(i) < count_q) && need_q[scan_idx_s] && !done_q[scan_idx_s]) begin
        pend_s = pend_s + CW'(1);
        if (!resp_found_s) begin
          resp_found_s = 1'b1;
          resp_idx_s   = scan_idx_s;
        end else begin
          resp_idx_s = resp_idx_s;
        end
      end else begin
        pend_s = pend_s;
      end
    end
  end

  // Head completion, optional bypass, and handshake qualifiers
  always_comb begin
    accept_resp_s = bus.data_ok && (drop_q == {CW{1'b0}}) && resp_found_s;
    ext_s         = extract_load(load_op_q[resp_idx_s], addr_q[resp_idx_s], bus.rdata);
    head_cpl_s    = (count_q != {CW{1'b0}}) && (!need_q[head_q] || done_q[head_q]);
`ifdef MEM_RESP_BYPASS_EN
    byp_hit_s   = accept_resp_s && (resp_idx_s == head_q);
    out_valid_s = head_cpl_s || byp_hit_s;
    result_s    = (byp_hit_s && (load_op_q[head_q] != 5'd0)) ? ext_s : data_q[head_q];
`else
    out_valid_s = head_cpl_s;
    result_s    = data_q[head_q];
`endif
    in_ready_s = (count_q < CW'(DEPTH)) || (out_valid_s && bus.out_ready);
    enq_s      = bus.in_valid && in_ready_s && !bus.flush;
    deq_s      = out_valid_s && bus.out_ready && !bus.flush;
`ifdef MEM_RESP_BYPASS_EN
    store_resp_s = accept_resp_s && !bus.flush && !(byp_hit_s && deq_s);
`else
    store_resp_s = accept_resp_s && !bus.flush;
`endif
  end

  // Pointer, occupancy and drop-counter next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (bus.flush) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
      drop_d  = drop_q + pend_s;
    end else begin
      head_d  = deq_s ? head_q + PW'(1) : head_q;
      tail_d  = enq_s ? tail_q + PW'(1) : tail_q;
      count_d = count_q + CW'(enq_s) - CW'(deq_s);
    end
    // A response is consumed by the drop counter unless a live entry takes it
    if (bus.data_ok && ((drop_q != {CW{1'b0}}) || (bus.flush && resp_found_s))) begin
      drop_d = drop_d - CW'(1);
    end else begin
      drop_d = drop_d;
    end
  end

  // Pointer and counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      drop_q  <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Entry storage: response capture first, so an enqueue into the same slot wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        gr_we_q[i]   <= 1'b0;
        dest_q[i]    <= 5'd0;
        pc_q[i]      <= 32'd0;
        exc_q[i]     <= 1'b0;
        need_q[i]    <= 1'b0;
        done_q[i]    <= 1'b0;
        load_op_q[i] <= 5'd0;
        addr_q[i]    <= 2'd0;
        data_q[i]    <= 32'd0;
      end
    end else begin
      if (store_resp_s) begin
        done_q[resp_idx_s] <= 1'b1;
        if (load_op_q[resp_idx_s] != 5'd0) begin
          data_q[resp_idx_s] <= ext_s;
        end
      end
      if (enq_s) begin
        gr_we_q[tail_q]   <= bus.in_gr_we;
        dest_q[tail_q]    <= bus.in_dest;
        pc_q[tail_q]      <= bus.in_pc;
        exc_q[tail_q]     <= bus.in_exc;
        need_q[tail_q]    <= bus.in_is_mem && !bus.in_exc;
        done_q[tail_q]    <= 1'b0;
        load_op_q[tail_q] <= bus.in_load_op;
        addr_q[tail_q]    <= bus.in_addr_lo;
        data_q[tail_q]    <= bus.in_result;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_gr_we  = out_valid_s ? gr_we_q[head_q] : 1'b0;
  assign bus.out_dest   = out_valid_s ? dest_q[head_q]  : 5'd0;
  assign bus.out_pc     = out_valid_s ? pc_q[head_q]    : 32'd0;
  assign bus.out_exc    = out_valid_s ? exc_q[head_q]   : 1'b0;
  assign bus.out_result = out_valid_s ? result_s        : 32'd0;
  assign bus.fwd_dest   = (out_valid_s && gr_we_q[head_q]) ? dest_q[head_q] : 5'd0;
endmodule

// File: tb/tb_mem_resp_queue.sv
// Scoreboard bench for mem_resp_queue (DEPTH=2, registered responses).
module tb_mem_resp_queue;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        exc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  mem_resp_queue_if bus_if ();

  mem_resp_queue #(.DEPTH(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] res,
                          input logic [4:0] dest, input logic we, input logic exc);
    exp_t e;
    e.pc = pc; e.result = res; e.dest = dest; e.gr_we = we; e.exc = exc;
    exp_q.push_back(e);
  endtask

  task automatic drive_in(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                          input logic we, input logic exc, input logic mem,
                          input logic [4:0] op, input logic [1:0] lo);
    bus_if.in_valid = 1'b1;   bus_if.in_pc = pc;      bus_if.in_result = res;
    bus_if.in_dest = dest;    bus_if.in_gr_we = we;   bus_if.in_exc = exc;
    bus_if.in_is_mem = mem;   bus_if.in_load_op = op; bus_if.in_addr_lo = lo;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                     input logic we, input logic exc, input logic mem,
                     input logic [4:0] op, input logic [1:0] lo);
    drive_in(pc, res, dest, we, exc, mem, op, lo);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] d);
    bus_if.data_ok = 1'b1;
    bus_if.rdata   = d;
    @(posedge clk); #1;
    bus_if.data_ok = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every WB handshake is compared against the oldest expectation
  always @(negedge clk) begin
    if (resetn && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %h result %h expected no output", bus_if.out_pc, bus_if.out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_pc", bus_if.out_pc, e.pc);
        chk("out_result", bus_if.out_result, e.result);
        chk("out_dest", {27'd0, bus_if.out_dest}, {27'd0, e.dest});
        chk("out_gr_we", {31'd0, bus_if.out_gr_we}, {31'd0, e.gr_we});
        chk("out_exc", {31'd0, bus_if.out_exc}, {31'd0, e.exc});
        chk("fwd_dest", {27'd0, bus_if.fwd_dest}, e.gr_we ? {27'd0, e.dest} : 32'd0);
      end
    end
  end

  logic [4:0]  ld_op  [5] = '{5'b00010, 5'b10000, 5'b00100, 5'b01000, 5'b00000};
  logic [1:0]  ld_lo  [5] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd0};
  logic [31:0] ld_rd  [5] = '{32'h80FF_FFFF, 32'h8001_0000, 32'h1234_8765, 32'h0000_F000, 32'h0000_0099};
  logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8765, 32'h0000_00F0, 32'h0000_0077};

  initial begin
    bus_if.in_valid = 1'b0;  bus_if.in_gr_we = 1'b0;    bus_if.in_dest = 5'd0;
    bus_if.in_pc = 32'd0;    bus_if.in_exc = 1'b0;      bus_if.in_is_mem = 1'b0;
    bus_if.in_load_op = 5'd0; bus_if.in_addr_lo = 2'd0; bus_if.in_result = 32'd0;
    bus_if.flush = 1'b0;     bus_if.data_ok = 1'b0;     bus_if.rdata = 32'd0;
    bus_if.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("rst_out_result", bus_if.out_result, 32'd0);
    chk("rst_out_pc", bus_if.out_pc, 32'd0);
    chk("rst_fwd_dest", {27'd0, bus_if.fwd_dest}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // ALU op, then an excepting memory op that must not wait for data_ok
    bus_if.out_ready = 1'b1;
    push_exp(32'h1C00_0000, 32'h0000_0005, 5'd3, 1'b1, 1'b0);
    enq(32'h1C00_0000, 32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    @(negedge clk);
    chk("alu_valid_next", {31'd0, bus_if.out_valid}, 32'd1);
    chk("alu_fwd_dest", {27'd0, bus_if.fwd_dest}, 32'd3);
    @(posedge clk); #1;
    push_exp(32'h1C00_0010, 32'h0000_0BAD, 5'd9, 1'b0, 1'b1);
    enq(32'h1C00_0010, 32'h0000_0BAD, 5'd9, 1'b0, 1'b1, 1'b1, 5'b00001, 2'd0);

    // Two back-to-back ld.w fill DEPTH=2
    push_exp(32'h1C00_0004, 32'h0000_0011, 5'd4, 1'b1, 1'b0);
    push_exp(32'h1C00_0008, 32'h0000_0022, 5'd5, 1'b1, 1'b0);
    enq(32'h1C00_0004, 32'hDEAD_0001, 5'd4, 1'b1, 1'b0, 1'b1, 5'b00001, 2'd0);
    enq(32'h1C00_0008, 32'hDEAD_0002, 5'd5, 1'b1, 1'b0, 1'b1, 5'b00001, 2'd0);
    drive_in(32'h1C00_000C, 32'h0000_0001, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    @(negedge clk);
    chk("full_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    chk("full_no_valid", {31'd0, bus_if.out_valid}, 32'd0);
    bus_if.in_valid = 1'b0;
    @(posedge clk); #1;
    resp(32'h0000_0011);
    resp(32'h0000_0022);
    drain("drain_ldw");

    // Load extraction variants and one store
    for (int i = 0; i < 5; i++) begin
      push_exp(32'h1C00_0020 + 32'(i * 4), ld_exp[i], 5'd10, 1'b1, 1'b0);
      enq(32'h1C00_0020 + 32'(i * 4), 32'h0000_0077, 5'd10, 1'b1, 1'b0, 1'b1, ld_op[i], ld_lo[i]);
      resp(ld_rd[i]);
      @(posedge clk); #1;
    end
    drain("drain_ext");

    // Flush with two loads outstanding: their responses must be dropped
    enq(32'h1C00_0040, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 5'b00001, 2'd0);
    enq(32'h1C00_0044, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 5'b00001, 2'd0);
    bus_if.flush = 1'b1;
    @(posedge clk); #1;
    bus_if.flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    @(posedge clk); #1;
    push_exp(32'h1C00_0048, 32'h0000_000C, 5'd13, 1'b1, 1'b0);
    enq(32'h1C00_0048, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 5'b00001, 2'd0);
    resp(32'h0000_000A);
    resp(32'h0000_000B);
    resp(32'h0000_000C);
    push_exp(32'h1C00_004C, 32'h0000_000D, 5'd14, 1'b1, 1'b0);
    enq(32'h1C00_004C, 32'h0, 5'd14, 1'b1, 1'b0, 1'b1, 5'b00001, 2'd0);
    resp(32'h0000_000D);
    drain("drain_flush");

    // Flush coincident with data_ok and an ignored in_valid
    enq(32'h1C00_0050, 32'h0, 5'd15, 1'b1, 1'b0, 1'b1, 5'b00001, 2'd0);
    drive_in(32'h1C00_0054, 32'h0000_1234, 5'd16, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    bus_if.flush = 1'b1; bus_if.data_ok = 1'b1; bus_if.rdata = 32'h0000_0055;
    @(posedge clk); #1;
    bus_if.flush = 1'b0; bus_if.data_ok = 1'b0; bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_ok_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    @(posedge clk); #1;
    push_exp(32'h1C00_0058, 32'h0000_0066, 5'd17, 1'b1, 1'b0);
    enq(32'h1C00_0058, 32'h0, 5'd17, 1'b1, 1'b0, 1'b1, 5'b00001, 2'd0);
    resp(32'h0000_0066);
    drain("drain_flush_ok");

    // Backpressure: full queue held, then released with enqueue on dequeue
    bus_if.out_ready = 1'b0;
    push_exp(32'h1C00_0100, 32'h0000_0100, 5'd7, 1'b1, 1'b0);
    push_exp(32'h1C00_0104, 32'h0000_0104, 5'd8, 1'b1, 1'b0);
    push_exp(32'h1C00_0108, 32'h0000_0108, 5'd9, 1'b1, 1'b0);
    enq(32'h1C00_0100, 32'h0000_0100, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    enq(32'h1C00_0104, 32'h0000_0104, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus_if.out_valid}, 32'd1);
      chk("hold_pc", bus_if.out_pc, 32'h1C00_0100);
      chk("hold_result", bus_if.out_result, 32'h0000_0100);
      chk("hold_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    drive_in(32'h1C00_0108, 32'h0000_0108, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("full_deq_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("deq_second_pc", bus_if.out_pc, 32'h1C00_0104);
    drain("drain_hold");

    // Asynchronous reset in the middle of a held entry
    bus_if.out_ready = 1'b0;
    enq(32'h1C00_0200, 32'h0000_0200, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    chk("mid_rst_fwd_dest", {27'd0, bus_if.fwd_dest}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
